// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive-side and consumer-side signal bundle for uart_rx_fifo
interface uart_rx_fifo_if #(
    parameter int DEPTH = 8
);
    logic                     rx_done;
    logic [7:0]               rx_data;
    logic [7:0]               dout;
    logic                     dout_valid;
    logic                     dout_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     overflow;

    modport master (
        output rx_done,
        output rx_data,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  count,
        input  full,
        input  overflow
    );

    modport slave (
        input  rx_done,
        input  rx_data,
        input  dout_ready,
        output dout,
        output dout_valid,
        output count,
        output full,
        output overflow
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - byte FIFO filled on each synchronized rising rx_done; sticky overflow flag under UART_RX_FIFO_OVERFLOW_EN
module uart_rx_fifo #(
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          nreset,
    uart_rx_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   push_req;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;

    logic full_w;
    logic pop_w;
    logic push_ok;

    // Synchronizer and history reset to the idle line level so reset release is not seen as a frame end.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.rx_done};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign push_req = sync_q[SYNC_STAGES-1] & ~hist_q;

    assign full_w  = (count_q == DEPTH_C);
    assign pop_w   = bus.dout_valid & bus.dout_ready;
    // When full, a concurrent pop frees the slot the write pointer already points at.
    assign push_ok = push_req & (~full_w | pop_w);

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr_q] <= bus.rx_data;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop_w) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (push_ok && !pop_w) begin
                count_q <= count_q + CW'(1);
            end else if (!push_ok && pop_w) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign bus.dout       = mem[rptr_q];
    assign bus.dout_valid = (count_q != '0);
    assign bus.count      = count_q;
    assign bus.full       = full_w;

`ifdef UART_RX_FIFO_OVERFLOW_EN
    logic overflow_q;

    // Sticky: only reset clears it.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            overflow_q <= 1'b0;
        end else if (push_req && full_w && !pop_w) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.overflow = overflow_q;
`else
    assign bus.overflow = 1'b0;
`endif

endmodule
